// File: rtl/lbm_pkg.sv
// lbm_pkg: shared types and D2Q9 lattice constants for the streaming sequencer.
//   dir_t   : 4-bit lattice direction index (0..8)
//   state_t : sequencer FSM states
//   CX/CY   : per-direction lattice velocity components
//   OPP     : index of the direction opposite to each direction
package lbm_pkg;

  typedef logic [3:0] dir_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  localparam int   NUM_DIRS = 9;
  localparam dir_t LAST_DIR = 4'd8;

  localparam int CX [NUM_DIRS] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int CY [NUM_DIRS] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  localparam dir_t OPP [NUM_DIRS] = '{4'd0, 4'd3, 4'd4, 4'd1, 4'd2,
                                      4'd7, 4'd8, 4'd5, 4'd6};

endpackage

// File: rtl/stream_dest_calc.sv
// stream_dest_calc: purely combinational destination lookup for one
// (cell, direction) pair of the streaming step.
//   x, y   : source cell coordinates
//   q      : source direction
//   addr   : destination cell index (source index when bouncing back)
//   dir    : destination direction (opposite direction when bouncing back)
//   bounce : destination falls outside the lattice
module stream_dest_calc
  import lbm_pkg::*;
#(
  parameter int GRID_X        = 16,
  parameter int GRID_Y        = 16,
  parameter int ADDRESS_WIDTH = $clog2(GRID_X * GRID_Y),
  parameter int XW            = (GRID_X > 1) ? $clog2(GRID_X) : 1,
  parameter int YW            = (GRID_Y > 1) ? $clog2(GRID_Y) : 1
) (
  input  logic [XW-1:0]            x,
  input  logic [YW-1:0]            y,
  input  dir_t                     q,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output dir_t                     dir,
  output logic                     bounce
);

  // Two bits beyond the coordinate width: one so x+1 at the far edge does not
  // wrap, one for the sign of x-1 at the near edge.
  localparam logic signed [XW+1:0] X_LIM = (XW+2)'(GRID_X);
  localparam logic signed [YW+1:0] Y_LIM = (YW+2)'(GRID_Y);

  logic signed [XW+1:0] dx;
  logic signed [YW+1:0] dy;

  always_comb begin
    dx     = $signed({2'b00, x}) + (XW+2)'(CX[q]);
    dy     = $signed({2'b00, y}) + (YW+2)'(CY[q]);
    bounce = dx[XW+1] | dy[YW+1] | (dx >= X_LIM) | (dy >= Y_LIM);
    if (bounce) begin
      addr = ADDRESS_WIDTH'(int'(y) * GRID_X + int'(x));
      dir  = OPP[q];
    end else begin
      addr = ADDRESS_WIDTH'(int'(dy[YW-1:0]) * GRID_X + int'(dx[XW-1:0]));
      dir  = q;
    end
  end

endmodule

// File: rtl/stream_sequencer.sv
// stream_sequencer: walks every (cell, direction) of a GRID_X x GRID_Y D2Q9
// lattice once per start, reading the source value and writing it to its
// streamed destination, or back into the source cell with the opposite
// direction when the destination leaves the lattice.
//   clk, rst_n              : clock, async active-low reset
//   start / busy / done     : sweep control and status
//   rd_req/rd_addr/rd_dir   : read request, held until rd_ack
//   rd_rvalid/rd_data       : read return
//   wr_valid/wr_addr/wr_dir/wr_data : write request, held until wr_ready
//   bounce_count            : bounce-back writes in the last sweep (saturating)
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_RD_REQ  | read request out, waiting for rd_ack
// ST_RD_WAIT | waiting for rd_rvalid
// ST_WR      | write request out, waiting for wr_ready
// ST_FIN     | one-cycle done pulse
module stream_sequencer
  import lbm_pkg::*;
#(
  parameter int GRID_X        = 16,
  parameter int GRID_Y        = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = $clog2(GRID_X * GRID_Y)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_req,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [3:0]               rd_dir,
  input  logic                     rd_ack,
  input  logic                     rd_rvalid,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     wr_valid,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [3:0]               wr_dir,
  output logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_ready,
  output logic [15:0]              bounce_count
);

  localparam int XW = (GRID_X > 1) ? $clog2(GRID_X) : 1;
  localparam int YW = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(GRID_X - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_Y - 1);

  state_t                   state, state_nxt;
  logic [XW-1:0]            x;
  logic [YW-1:0]            y;
  dir_t                     q;
  logic [DATA_WIDTH-1:0]    data_r;
  logic [ADDRESS_WIDTH-1:0] src_addr;
  logic [ADDRESS_WIDTH-1:0] dest_addr;
  dir_t                     dest_dir;
  logic                     dest_bounce;
  logic                     last_elem;

  assign src_addr  = ADDRESS_WIDTH'(int'(y) * GRID_X + int'(x));
  assign last_elem = (x == X_MAX) && (y == Y_MAX) && (q == LAST_DIR);

  stream_dest_calc #(
    .GRID_X       (GRID_X),
    .GRID_Y       (GRID_Y),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .XW           (XW),
    .YW           (YW)
  ) u_dest_calc (
    .x     (x),
    .y     (y),
    .q     (q),
    .addr  (dest_addr),
    .dir   (dest_dir),
    .bounce(dest_bounce)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start)     state_nxt = ST_RD_REQ;
      ST_RD_REQ:  if (rd_ack)    state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_rvalid) state_nxt = ST_WR;
      ST_WR:      if (wr_ready)  state_nxt = last_elem ? ST_FIN : ST_RD_REQ;
      ST_FIN:                    state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    done     = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    rd_dir   = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_dir   = '0;
    wr_data  = '0;
    case (state)
      ST_RD_REQ: begin
        rd_req  = 1'b1;
        rd_addr = src_addr;
        rd_dir  = q;
      end
      ST_WR: begin
        wr_valid = 1'b1;
        wr_addr  = dest_addr;
        wr_dir   = dest_dir;
        wr_data  = data_r;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Sweep counters, read capture and bounce tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x            <= '0;
      y            <= '0;
      q            <= '0;
      data_r       <= '0;
      bounce_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          x            <= '0;
          y            <= '0;
          q            <= '0;
          bounce_count <= '0;
        end
        ST_RD_WAIT: if (rd_rvalid) data_r <= rd_data;
        ST_WR: if (wr_ready) begin
          if (dest_bounce && (bounce_count != 16'hFFFF))
            bounce_count <= bounce_count + 16'd1;
          if (q == LAST_DIR) begin
            q <= '0;
            if (x == X_MAX) begin
              x <= '0;
              y <= (y == Y_MAX) ? '0 : y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end else begin
            q <= q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sequencer.sv
module tb_stream_sequencer;
  localparam int GX = 4;
  localparam int GY = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = GX * GY * 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_req, wr_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0]    rd_dir, wr_dir;
  logic          rd_ack = 1'b0;
  logic          rd_rvalid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] wr_data;
  logic          wr_ready = 1'b0;
  logic [15:0]   bounce_count;

  stream_sequencer #(
    .GRID_X(GX), .GRID_Y(GY), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_dir(rd_dir), .rd_ack(rd_ack),
    .rd_rvalid(rd_rvalid), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_dir(wr_dir), .wr_data(wr_data),
    .wr_ready(wr_ready), .bounce_count(bounce_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    int            dir;
    logic [DW-1:0] data;
  } wr_t;

  int total = 0;
  int bad   = 0;

  // memory contents indexed by (cell*9 + direction)
  logic [DW-1:0] mem [N];
  wr_t           wr_q[$];
  int            exp_addr [N];
  int            exp_dir  [N];
  int            exp_bounces;

  int ack_pct = 100;
  int rv_pct  = 100;
  int wr_pct  = 100;
  bit noise_en = 1'b0;
  bit stall_wr = 1'b0;

  bit pend = 1'b0;
  int pend_idx = 0;
  int done_cnt = 0;
  int busy_cycles = 0;

  // memory / sink model, driven on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_ack    = 1'b0;
      rd_rvalid = 1'b0;
      wr_ready  = 1'b0;
      pend      = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (busy) busy_cycles++;
      if (pend && int'($urandom_range(99)) < rv_pct) begin
        rd_rvalid = 1'b1;
        rd_data   = mem[pend_idx];
        pend      = 1'b0;
      end else if (!pend && noise_en && $urandom_range(1) == 1) begin
        rd_rvalid = 1'b1;
        rd_data   = $urandom;
      end else begin
        rd_rvalid = 1'b0;
        rd_data   = $urandom;
      end
      rd_ack = rd_req && (int'($urandom_range(99)) < ack_pct);
      if (rd_ack) begin
        pend     = 1'b1;
        pend_idx = int'(rd_addr) * 9 + int'(rd_dir);
      end
      wr_ready = wr_valid && !stall_wr && (int'($urandom_range(99)) < wr_pct);
      if (wr_valid && wr_ready)
        wr_q.push_back('{int'(wr_addr), int'(wr_dir), wr_data});
    end
  end

  // Reference: for each source (x,y,q) in visit order, stream to (x+cx, y+cy)
  // or bounce back into the source cell with the reversed direction.
  function automatic void build_model();
    int cxv [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    int cyv [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
    int oppv[9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};
    int i = 0;
    exp_bounces = 0;
    for (int yy = 0; yy < GY; yy++)
      for (int xx = 0; xx < GX; xx++)
        for (int qq = 0; qq < 9; qq++) begin
          int dx = xx + cxv[qq];
          int dy = yy + cyv[qq];
          if (dx >= 0 && dx < GX && dy >= 0 && dy < GY) begin
            exp_addr[i] = dy * GX + dx;
            exp_dir[i]  = qq;
          end else begin
            exp_addr[i] = yy * GX + xx;
            exp_dir[i]  = oppv[qq];
            exp_bounces++;
          end
          i++;
        end
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < N; i++) mem[i] = $urandom;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, rd_req, wr_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: busy/done/rd_req/wr_valid=%b required 0000", {busy, done, rd_req, wr_valid});
    end
    total++;
    if (rd_addr !== '0 || rd_dir !== '0 || wr_addr !== '0 || wr_dir !== '0 || wr_data !== '0) begin
      bad++;
      $display("FAIL reset_data: rd_addr=%0d rd_dir=%0d wr_addr=%0d wr_dir=%0d wr_data=%h required all 0",
               rd_addr, rd_dir, wr_addr, wr_dir, wr_data);
    end
    total++;
    if (bounce_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_bounce: got %0d required 0", bounce_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || rd_req !== 1'b0 || wr_valid !== 1'b0 || done !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL idle_quiet: active cycles=%0d required 0", seen);
    end
  endtask

  task automatic check_sweep(input string tag, input int wb, input int db);
    int got, errs, first;
    got = wr_q.size() - wb;
    total++;
    if (got != N) begin
      bad++;
      $display("FAIL %s_count: writes=%0d required %0d", tag, got, N);
    end
    errs = 0;
    first = -1;
    for (int i = 0; i < N && i < got; i++)
      if (wr_q[wb+i].addr != exp_addr[i] || wr_q[wb+i].dir != exp_dir[i] ||
          wr_q[wb+i].data !== mem[i]) begin
        if (first < 0) first = i;
        errs++;
      end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s_content: %0d bad writes, first #%0d addr=%0d dir=%0d data=%h required addr=%0d dir=%0d data=%h",
               tag, errs, first, wr_q[wb+first].addr, wr_q[wb+first].dir, wr_q[wb+first].data,
               exp_addr[first], exp_dir[first], mem[first]);
    end
    total++;
    if (done_cnt - db != 1) begin
      bad++;
      $display("FAIL %s_done: pulses=%0d required 1", tag, done_cnt - db);
    end
    total++;
    if (bounce_count !== 16'(exp_bounces)) begin
      bad++;
      $display("FAIL %s_bounce: got %0d required %0d", tag, bounce_count, exp_bounces);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_zero_wait();
    int wb, db, bb;
    bit to;
    ack_pct = 100; rv_pct = 100; wr_pct = 100; noise_en = 1'b0;
    fill_mem();
    wb = wr_q.size(); db = done_cnt; bb = busy_cycles;
    pulse_start();
    wait_done(to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL zero_wait_timeout: done not seen, required within budget");
    end
    check_sweep("zero_wait", wb, db);
    total++;
    if (bounce_count !== 16'd44) begin
      bad++;
      $display("FAIL zero_wait_bounce44: got %0d required 44", bounce_count);
    end
    total++;
    if (busy_cycles - bb != 3 * N + 1) begin
      bad++;
      $display("FAIL zero_wait_latency: busy cycles=%0d required %0d", busy_cycles - bb, 3 * N + 1);
    end
    if (wr_q.size() - wb == N) begin
      // cell (1,1) q=1 is element 46; cell (0,0) q=7 is element 7; cell (2,1) q=0 is element 54
      total++;
      if (wr_q[wb+46].addr != 6 || wr_q[wb+46].dir != 1) begin
        bad++;
        $display("FAIL cell11_q1: addr=%0d dir=%0d required addr=6 dir=1", wr_q[wb+46].addr, wr_q[wb+46].dir);
      end
      total++;
      if (wr_q[wb+7].addr != 0 || wr_q[wb+7].dir != 5) begin
        bad++;
        $display("FAIL cell00_q7: addr=%0d dir=%0d required addr=0 dir=5", wr_q[wb+7].addr, wr_q[wb+7].dir);
      end
      total++;
      if (wr_q[wb+54].addr != 6 || wr_q[wb+54].dir != 0) begin
        bad++;
        $display("FAIL cell21_q0: addr=%0d dir=%0d required addr=6 dir=0", wr_q[wb+54].addr, wr_q[wb+54].dir);
      end
    end
  endtask

  task automatic test_random_wait();
    int wb, db;
    bit to;
    for (int r = 0; r < 2; r++) begin
      ack_pct = 40 + 20 * r; rv_pct = 50; wr_pct = 60; noise_en = 1'b1;
      fill_mem();
      wb = wr_q.size(); db = done_cnt;
      pulse_start();
      wait_done(to);
      total++;
      if (to) begin
        bad++;
        $display("FAIL random_wait_timeout: done not seen, required within budget");
      end
      check_sweep("random_wait", wb, db);
    end
    noise_en = 1'b0;
  endtask

  task automatic test_wr_stall();
    int wb, db, n, idx, found;
    logic [AW-1:0] sa;
    logic [3:0]    sd;
    logic [DW-1:0] sdat;
    bit to;
    ack_pct = 100; rv_pct = 100; wr_pct = 100; noise_en = 1'b1;
    fill_mem();
    wb = wr_q.size(); db = done_cnt;
    pulse_start();
    for (n = 0; n < 2000 && wr_q.size() - wb < 20; n++) @(negedge clk);
    @(posedge clk); #1 stall_wr = 1'b1;
    found = 0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (wr_valid) begin
        found = 1;
        break;
      end
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL stall_reach_wr: wr_valid=0 required 1 within 10 cycles");
    end
    sa = wr_addr; sd = wr_dir; sdat = wr_data;
    idx = wr_q.size() - wb;
    total++;
    if (idx >= N || int'(sa) != exp_addr[idx] || int'(sd) != exp_dir[idx] || sdat !== mem[idx]) begin
      bad++;
      $display("FAIL stall_element: element #%0d addr=%0d dir=%0d data=%h not the reference write", idx, sa, sd, sdat);
    end
    repeat (5) begin
      @(negedge clk);
      total++;
      if (wr_valid !== 1'b1 || wr_addr !== sa || wr_dir !== sd || wr_data !== sdat ||
          wr_q.size() - wb != idx) begin
        bad++;
        $display("FAIL stall_hold: valid=%b addr=%0d dir=%0d data=%h writes=%0d required 1/%0d/%0d/%h/%0d",
                 wr_valid, wr_addr, wr_dir, wr_data, wr_q.size() - wb, sa, sd, sdat, idx);
      end
    end
    stall_wr = 1'b0;
    wait_done(to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL stall_timeout: done not seen, required within budget");
    end
    check_sweep("stall", wb, db);
    noise_en = 1'b0;
  endtask

  task automatic test_start_mid();
    int wb, db, cyc, got_done;
    int p0, p1, p2;
    ack_pct = 100; rv_pct = 100; wr_pct = 100;
    fill_mem();
    wb = wr_q.size(); db = done_cnt;
    p0 = $urandom_range(5, 140);
    p1 = $urandom_range(141, 280);
    p2 = $urandom_range(281, 420);
    pulse_start();
    got_done = 0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start = (cyc == p0 || cyc == p1 || cyc == p2);
      if (done) begin
        got_done = 1;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (got_done == 0) begin
      bad++;
      $display("FAIL start_mid_timeout: done not seen, required within budget");
    end
    check_sweep("start_mid", wb, db);
  endtask

  task automatic test_reset_mid();
    int wb, db, act;
    bit to;
    ack_pct = 70; rv_pct = 70; wr_pct = 70;
    fill_mem();
    pulse_start();
    repeat ($urandom_range(50, 200)) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || rd_req !== 1'b0 || wr_valid !== 1'b0 || bounce_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_abort: busy=%b rd_req=%b wr_valid=%b bounce=%0d required 0/0/0/0",
               busy, rd_req, wr_valid, bounce_count);
    end
    act = 0;
    repeat (3) begin
      @(negedge clk);
      if (rd_req !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0) act++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rd_req !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0) act++;
    end
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: active cycles=%0d required 0", act);
    end
    wb = wr_q.size(); db = done_cnt;
    pulse_start();
    wait_done(to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL reset_mid_timeout: done not seen, required within budget");
    end
    check_sweep("after_reset", wb, db);
  endtask

  initial begin
    build_model();
    test_reset();
    test_zero_wait();
    test_wr_stall();
    test_random_wait();
    test_start_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
